// File: rtl/mem_bounds_port.sv
// mem_bounds_port: single-clock scratch RAM with range-checked accesses.
//
// One write port and one registered read port. Every address is checked
// against [ADDR_LO : ADDR_LO+DEPTH-1] with a signed compare. Reads return
// a whole word, a single bit or a SLICE-bit part-select, zero-extended to
// OUT_WIDTH. Out-of-range words/bits read back as a fill value (x or
// FILL_BIT) and raise o_rd_oob for that access only.
// Word bits are numbered ascending from the MSB: word bit 0 is data[WIDTH-1].
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_wr_en/addr/data     write strobe, signed index, data
//   o_wr_oob              previous cycle's write was out of range (discarded)
//   i_rd_en/addr          read strobe, signed index
//   i_rd_mode             0 word, 1 bit, 2 slice, 3 reserved
//   i_rd_bit              bit / slice start index (unsigned)
//   o_rd_data/valid/oob   registered read result, valid, out-of-range flag
module mem_bounds_port #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter int               ADDR_LO   = 0,
  parameter int unsigned      ADDR_W    = 4,
  parameter int unsigned      OUT_WIDTH = 32,
  parameter int unsigned      SLICE     = 2,
  parameter bit               OOB_X     = 1'b1,
  parameter logic             FILL_BIT  = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic signed [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic                     o_wr_oob,
  input  logic                     i_rd_en,
  input  logic signed [ADDR_W-1:0] i_rd_addr,
  input  logic [1:0]               i_rd_mode,
  input  logic [$clog2(WIDTH):0]   i_rd_bit,
  output logic [OUT_WIDTH-1:0]     o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_rd_oob
);

  localparam int          ADDR_HI   = ADDR_LO + int'(DEPTH) - 1;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SEL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned OUT_SEL_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  // Storage is never reset; it powers up holding INIT_VAL.
  logic [WIDTH-1:0] r_mem [DEPTH] = '{default: INIT_VAL};

  logic [OUT_WIDTH-1:0] r_rd_data;
  logic                 r_rd_valid;
  logic                 r_rd_oob;
  logic                 r_wr_oob;

  int                   w_wr_addr;
  int                   w_rd_addr;
  int unsigned          w_bit_start;
  logic                 w_wr_hit;
  logic                 w_rd_hit;
  logic [IDX_W-1:0]     w_wr_idx;
  logic [IDX_W-1:0]     w_rd_idx;
  logic [WIDTH-1:0]     w_rd_word;
  logic                 w_fill;
  logic [OUT_WIDTH-1:0] w_rd_data;
  logic                 w_rd_oob;

  // Sign-extend the addresses so the range check is a true signed compare.
  assign w_wr_addr   = int'(i_wr_addr);
  assign w_rd_addr   = int'(i_rd_addr);
  assign w_bit_start = int'(i_rd_bit);

  assign w_wr_hit = (w_wr_addr >= ADDR_LO) && (w_wr_addr <= ADDR_HI);
  assign w_rd_hit = (w_rd_addr >= ADDR_LO) && (w_rd_addr <= ADDR_HI);
  assign w_wr_idx = IDX_W'(w_wr_addr - ADDR_LO);
  assign w_rd_idx = IDX_W'(w_rd_addr - ADDR_LO);

  assign w_rd_word = w_rd_hit ? r_mem[w_rd_idx] : '0;
  assign w_fill    = OOB_X ? 1'bx : FILL_BIT;

  // Ascending bit b of a word lives at physical position WIDTH-1-b.
  function automatic logic pick(input logic [WIDTH-1:0] word, input int unsigned b);
    return word[SEL_W'(WIDTH - 1 - b)];
  endfunction

  always_comb begin
    w_rd_data = '0;
    w_rd_oob  = 1'b0;
    case (i_rd_mode)
      2'd0: begin
        if (w_rd_hit) begin
          w_rd_data[WIDTH-1:0] = w_rd_word;
        end else begin
          w_rd_data[WIDTH-1:0] = {WIDTH{w_fill}};
          w_rd_oob             = 1'b1;
        end
      end
      2'd1: begin
        if (w_rd_hit && (w_bit_start < WIDTH)) begin
          w_rd_data[0] = pick(w_rd_word, w_bit_start);
        end else begin
          w_rd_data[0] = w_fill;
          w_rd_oob     = 1'b1;
        end
      end
      2'd2: begin
        // Each slice bit is range-checked on its own; bit rd_bit lands in the MSB.
        for (int unsigned k = 0; k < SLICE; k++) begin
          if (w_rd_hit && ((w_bit_start + k) < WIDTH)) begin
            w_rd_data[OUT_SEL_W'(SLICE - 1 - k)] = pick(w_rd_word, w_bit_start + k);
          end else begin
            w_rd_data[OUT_SEL_W'(SLICE - 1 - k)] = w_fill;
            w_rd_oob                             = 1'b1;
          end
        end
      end
      default: begin
        w_rd_oob = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_wr_oob   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      r_rd_oob   <= i_rd_en & w_rd_oob;
      r_wr_oob   <= i_wr_en & ~w_wr_hit;
      if (i_rd_en) begin
        r_rd_data <= w_rd_data;
      end
    end
  end

  // Writes ignore reset; reads sample the old word at the same edge.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && w_wr_hit) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_oob   = r_rd_oob;
  assign o_wr_oob   = r_wr_oob;

endmodule
